// File: rtl/mem_hazard_ctrl.sv
// Pipeline sequencing controller: write enables for PC and the four pipeline
// registers, the data-memory handshake with a timeout watchdog, and the
// single-bubble load-use interlock.
module mem_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             dmem_ready,
    input  logic             MemRead_EX,
    input  logic [4:0]       RD_EX,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    output logic             dmem_req,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StErr  = 2'd2
    } state_e;

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

    state_e             r_state;
    state_e             w_state_d;
    logic [15:0]        r_wait_cnt;
    logic [15:0]        w_wait_cnt_d;
    logic               r_mem_error;
    logic               w_mem_error_d;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic w_mem_op;
    logic w_lu_hazard;

    // Raw (pre-reset-override) output values from the FSM.
    logic w_req;
    logic w_pc_we;
    logic w_ifid_we;
    logic w_idex_we;
    logic w_idex_flush;
    logic w_exmem_we;
    logic w_memwb_we;

    // Hazard and memory-operation decode.
    always_comb begin
        w_mem_op    = MemRead_MEM | MemWrite_MEM;
        w_lu_hazard = MemRead_EX && (RD_EX != 5'd0) &&
                      ((RD_EX == RS1_ID) || (RD_EX == RS2_ID));
    end

    // Next-state, watchdog counter and Mealy outputs.
    always_comb begin
        w_state_d     = r_state;
        w_wait_cnt_d  = r_wait_cnt;
        w_mem_error_d = r_mem_error;
        w_req         = 1'b0;
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_idex_we     = 1'b1;
        w_idex_flush  = 1'b0;
        w_exmem_we    = 1'b1;
        w_memwb_we    = 1'b1;

        unique case (r_state)
            StIdle: begin
                w_req = w_mem_op;
                if (w_mem_op && !dmem_ready) begin
                    // Memory stall freezes everything; it outranks the bubble.
                    w_pc_we      = 1'b0;
                    w_ifid_we    = 1'b0;
                    w_idex_we    = 1'b0;
                    w_exmem_we   = 1'b0;
                    w_memwb_we   = 1'b0;
                    w_state_d    = StWait;
                    w_wait_cnt_d = 16'd1;
                end else if (w_lu_hazard) begin
                    w_pc_we      = 1'b0;
                    w_ifid_we    = 1'b0;
                    w_idex_flush = 1'b1;
                end
            end
            StWait: begin
                // Request held even if mem_op drops: MEM stage is frozen.
                w_req = 1'b1;
                if (dmem_ready) begin
                    w_state_d    = StIdle;
                    w_wait_cnt_d = 16'd0;
                    if (w_lu_hazard) begin
                        w_pc_we      = 1'b0;
                        w_ifid_we    = 1'b0;
                        w_idex_flush = 1'b1;
                    end
                end else begin
                    w_pc_we    = 1'b0;
                    w_ifid_we  = 1'b0;
                    w_idex_we  = 1'b0;
                    w_exmem_we = 1'b0;
                    w_memwb_we = 1'b0;
                    if (r_wait_cnt == TimeoutVal) begin
                        w_state_d     = StErr;
                        w_mem_error_d = 1'b1;
                    end else begin
                        w_wait_cnt_d = r_wait_cnt + 16'd1;
                    end
                end
            end
            StErr: begin
                w_pc_we    = 1'b0;
                w_ifid_we  = 1'b0;
                w_idex_we  = 1'b0;
                w_exmem_we = 1'b0;
                w_memwb_we = 1'b0;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs: reset forces the free-running pipeline pattern immediately.
    always_comb begin
        dmem_req     = reset ? 1'b0 : w_req;
        PC_write     = reset ? 1'b1 : w_pc_we;
        IF_ID_write  = reset ? 1'b1 : w_ifid_we;
        ID_EX_write  = reset ? 1'b1 : w_idex_we;
        ID_EX_flush  = reset ? 1'b0 : w_idex_flush;
        EX_MEM_write = reset ? 1'b1 : w_exmem_we;
        MEM_WB_write = reset ? 1'b1 : w_memwb_we;
        mem_error    = r_mem_error;
        stall_cycles = r_stall_cycles;
    end

    // FSM state, watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_wait_cnt  <= 16'd0;
            r_mem_error <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_wait_cnt  <= w_wait_cnt_d;
            r_mem_error <= w_mem_error_d;
        end
    end

    // Saturating count of cycles in which MEM_WB did not advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (!w_memwb_we && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

endmodule
